// File: rtl/joker_ep_out_buf.sv
// EP2 OUT single-packet buffer feeding joker_control: captures one USB OUT packet into RAM
// and holds it for random-access reads until released via arm/arm_ack. Optional: EP_OUT_STATS_EN.
module joker_ep_out_buf #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DROP_ZLP   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  usb_out_data,
    input  logic        usb_out_valid,
    input  logic        usb_out_last,
    input  logic        usb_out_zlp,
    output logic        usb_out_ready,
    output logic        buf_out_hasdata,
    output logic [9:0]  buf_out_len,
    input  logic [10:0] buf_out_addr,
    output logic [7:0]  buf_out_q,
    input  logic        buf_out_arm,
    output logic        buf_out_arm_ack,
`ifdef EP_OUT_STATS_EN
    output logic [15:0] pkt_cnt,
    output logic [7:0]  drop_cnt,
`endif
    output logic        buf_out_ovf
);

    localparam int unsigned             CAP   = (1 << DEPTH_LOG2) - 1;
    localparam logic [DEPTH_LOG2-1:0]   CAP_W = DEPTH_LOG2'(CAP);

    typedef enum logic [2:0] {
        S_EMPTY = 3'd0,
        S_FILL  = 3'd1,
        S_FULL  = 3'd2,
        S_ACK   = 3'd3,
        S_REL   = 3'd4
    } state_t;

    state_t                 state_q;
    logic                   ready_q;
    logic                   hasdata_q;
    logic [9:0]             len_q;
    logic                   arm_ack_q;
    logic                   ovf_q;
    logic [DEPTH_LOG2-1:0]  wptr_q;
    logic [DEPTH_LOG2-1:0]  wptr_d;
    logic [DEPTH_LOG2-1:0]  rd_addr_q;
    logic [7:0]             q_q;
    logic [7:0]             mem_q [0:CAP];

    logic                   accept_s;
    logic                   wr_en_s;
    logic [DEPTH_LOG2-1:0]  wr_addr_s;
    logic                   drop_hit_s;
    logic                   go_full_s;
    logic                   unused_addr_s;

    assign accept_s      = usb_out_valid && ready_q;
    assign unused_addr_s = ^buf_out_addr;

    // Write-side decode: RAM write strobe, next write pointer, overflow drop and packet completion
    always_comb begin
        wptr_d     = wptr_q;
        wr_en_s    = 1'b0;
        wr_addr_s  = wptr_q;
        drop_hit_s = 1'b0;
        go_full_s  = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (accept_s) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = '0;
                    wptr_d    = DEPTH_LOG2'(1);
                    go_full_s = usb_out_last;
                end else begin
                    // Idle pointer is held at 0 so a presented ZLP reports len=0
                    wptr_d    = '0;
                    go_full_s = usb_out_zlp && (DROP_ZLP == 0);
                end
            end
            S_FILL: begin
                if (accept_s) begin
                    if (wptr_q != CAP_W) begin
                        wr_en_s = 1'b1;
                        wptr_d  = wptr_q + DEPTH_LOG2'(1);
                    end else begin
                        drop_hit_s = 1'b1;
                    end
                    go_full_s = usb_out_last;
                end else begin
                    go_full_s = 1'b0;
                end
            end
            default: begin
                wptr_d = wptr_q;
            end
        endcase
    end

    // Packet-ownership FSM with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_EMPTY;
            ready_q   <= 1'b1;
            hasdata_q <= 1'b0;
            len_q     <= 10'd0;
            arm_ack_q <= 1'b0;
            ovf_q     <= 1'b0;
            wptr_q    <= '0;
        end else begin
            case (state_q)
                S_EMPTY, S_FILL: begin
                    wptr_q <= wptr_d;
                    if (state_q == S_EMPTY && (accept_s || go_full_s)) begin
                        ovf_q <= 1'b0;
                    end else if (drop_hit_s) begin
                        ovf_q <= 1'b1;
                    end
                    if (go_full_s) begin
                        state_q   <= S_FULL;
                        ready_q   <= 1'b0;
                        hasdata_q <= 1'b1;
                        len_q     <= 10'(wptr_d);
                    end else if (accept_s) begin
                        state_q <= S_FILL;
                    end
                end
                S_FULL: begin
                    if (buf_out_arm) begin
                        state_q   <= S_ACK;
                        arm_ack_q <= 1'b1;
                        hasdata_q <= 1'b0;
                        len_q     <= 10'd0;
                    end
                end
                S_ACK: begin
                    state_q   <= S_REL;
                    arm_ack_q <= 1'b0;
                end
                S_REL: begin
                    if (!buf_out_arm) begin
                        state_q <= S_EMPTY;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_EMPTY;
                    ready_q   <= 1'b1;
                    hasdata_q <= 1'b0;
                    len_q     <= 10'd0;
                    arm_ack_q <= 1'b0;
                end
            endcase
        end
    end

    // Packet RAM write port; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= usb_out_data;
        end
    end

    // Two-stage read pipeline: registered address, then registered data
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_addr_q <= '0;
            q_q       <= 8'd0;
        end else begin
            rd_addr_q <= buf_out_addr[DEPTH_LOG2-1:0];
            q_q       <= mem_q[rd_addr_q];
        end
    end

`ifdef EP_OUT_STATS_EN
    logic [15:0] pkt_cnt_q;
    logic [7:0]  drop_cnt_q;
    logic        drop_inc_s;

    assign drop_inc_s = (state_q == S_EMPTY && !accept_s && usb_out_zlp && DROP_ZLP != 0)
                      || (drop_hit_s && !ovf_q);

    // Wrapping statistics counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            pkt_cnt_q  <= 16'd0;
            drop_cnt_q <= 8'd0;
        end else begin
            if (go_full_s) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
            if (drop_inc_s) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

    assign usb_out_ready   = ready_q;
    assign buf_out_hasdata = hasdata_q;
    assign buf_out_len     = len_q;
    assign buf_out_q       = q_q;
    assign buf_out_arm_ack = arm_ack_q;
    assign buf_out_ovf     = ovf_q;

endmodule

// File: tb/tb_joker_ep_out_buf.sv
// Directed self-checking bench for joker_ep_out_buf (default DROP_ZLP=1 plus a DROP_ZLP=0 instance).
module tb_joker_ep_out_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  usb_out_data;
    logic        usb_out_valid;
    logic        usb_out_last;
    logic        usb_out_zlp;
    logic        usb_out_ready;
    logic        buf_out_hasdata;
    logic [9:0]  buf_out_len;
    logic [10:0] buf_out_addr;
    logic [7:0]  buf_out_q;
    logic        buf_out_arm;
    logic        buf_out_arm_ack;
    logic        buf_out_ovf;

    logic        zlp_z;
    logic        arm_z;
    logic        ready_z;
    logic        hasdata_z;
    logic [9:0]  len_z;
    logic [7:0]  q_z;
    logic        ack_z;
    logic        ovf_z;

`ifdef EP_OUT_STATS_EN
    logic [15:0] pkt_cnt;
    logic [7:0]  drop_cnt;
    logic [15:0] pkt_cnt_z;
    logic [7:0]  drop_cnt_z;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    joker_ep_out_buf u_dut (
        .clk             (clk),
        .reset           (reset),
        .usb_out_data    (usb_out_data),
        .usb_out_valid   (usb_out_valid),
        .usb_out_last    (usb_out_last),
        .usb_out_zlp     (usb_out_zlp),
        .usb_out_ready   (usb_out_ready),
        .buf_out_hasdata (buf_out_hasdata),
        .buf_out_len     (buf_out_len),
        .buf_out_addr    (buf_out_addr),
        .buf_out_q       (buf_out_q),
        .buf_out_arm     (buf_out_arm),
        .buf_out_arm_ack (buf_out_arm_ack),
`ifdef EP_OUT_STATS_EN
        .pkt_cnt         (pkt_cnt),
        .drop_cnt        (drop_cnt),
`endif
        .buf_out_ovf     (buf_out_ovf)
    );

    joker_ep_out_buf #(.DROP_ZLP(0)) u_dut_zlp (
        .clk             (clk),
        .reset           (reset),
        .usb_out_data    (8'd0),
        .usb_out_valid   (1'b0),
        .usb_out_last    (1'b0),
        .usb_out_zlp     (zlp_z),
        .usb_out_ready   (ready_z),
        .buf_out_hasdata (hasdata_z),
        .buf_out_len     (len_z),
        .buf_out_addr    (11'd0),
        .buf_out_q       (q_z),
        .buf_out_arm     (arm_z),
        .buf_out_arm_ack (ack_z),
`ifdef EP_OUT_STATS_EN
        .pkt_cnt         (pkt_cnt_z),
        .drop_cnt        (drop_cnt_z),
`endif
        .buf_out_ovf     (ovf_z)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic is_last);
        usb_out_data  = d;
        usb_out_valid = 1'b1;
        usb_out_last  = is_last;
        tick();
        usb_out_valid = 1'b0;
        usb_out_last  = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [10:0] a, input logic [7:0] exp);
        buf_out_addr = a;
        tick();
        tick();
        chk(tag, {24'd0, buf_out_q}, {24'd0, exp});
    endtask

    task automatic release_pkt();
        buf_out_arm = 1'b1;
        tick();
        tick();
        buf_out_arm = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0; usb_out_data = 8'd0; usb_out_valid = 1'b0; usb_out_last = 1'b0;
        usb_out_zlp = 1'b0; buf_out_addr = 11'd0; buf_out_arm = 1'b0; zlp_z = 1'b0; arm_z = 1'b0;
        tick();
        tick();
        chk("rst_ready",   {31'd0, usb_out_ready},   32'd1);
        chk("rst_hasdata", {31'd0, buf_out_hasdata}, 32'd0);
        chk("rst_len",     {22'd0, buf_out_len},     32'd0);
        chk("rst_ack",     {31'd0, buf_out_arm_ack}, 32'd0);
        chk("rst_ovf",     {31'd0, buf_out_ovf},     32'd0);
        chk("rst_q",       {24'd0, buf_out_q},       32'd0);
        reset = 1'b1;
        tick();

        // 3-byte packet
        send_byte(8'h0A, 1'b0);
        send_byte(8'h05, 1'b0);
        chk("p1_not_yet", {31'd0, buf_out_hasdata}, 32'd0);
        send_byte(8'h80, 1'b1);
        chk("p1_hasdata", {31'd0, buf_out_hasdata}, 32'd1);
        chk("p1_len",     {22'd0, buf_out_len},     32'd3);
        chk("p1_ready",   {31'd0, usb_out_ready},   32'd0);
        read_chk("p1_rd1", 11'd1, 8'h05);
        read_chk("p1_rd0", 11'd0, 8'h0A);
        read_chk("p1_rd2", 11'd2, 8'h80);

        // bytes offered while full must be ignored
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        chk("full_len",    {22'd0, buf_out_len},     32'd3);
        chk("full_hasdat", {31'd0, buf_out_hasdata}, 32'd1);
        read_chk("full_rd0", 11'd0, 8'h0A);

        // release handshake
        buf_out_arm = 1'b1;
        tick();
        chk("ack_hi",      {31'd0, buf_out_arm_ack}, 32'd1);
        chk("ack_hasdata", {31'd0, buf_out_hasdata}, 32'd0);
        chk("ack_len",     {22'd0, buf_out_len},     32'd0);
        tick();
        chk("ack_lo",      {31'd0, buf_out_arm_ack}, 32'd0);
        chk("rel_ready",   {31'd0, usb_out_ready},   32'd0);
        tick();
        chk("rel_ack_lo2", {31'd0, buf_out_arm_ack}, 32'd0);
        chk("rel_ready2",  {31'd0, usb_out_ready},   32'd0);
        buf_out_arm = 1'b0;
        tick();
        chk("rel_done",    {31'd0, usb_out_ready},   32'd1);

        // second packet after release
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        chk("p2_len", {22'd0, buf_out_len}, 32'd4);
        read_chk("p2_rd0", 11'd0, 8'h11);
        read_chk("p2_rd3", 11'd3, 8'h44);
        release_pkt();

        // arm while empty produces no ack
        buf_out_arm = 1'b1;
        tick();
        chk("arm_empty_ack", {31'd0, buf_out_arm_ack}, 32'd0);
        tick();
        chk("arm_empty_ack2", {31'd0, buf_out_arm_ack}, 32'd0);
        chk("arm_empty_rdy",  {31'd0, usb_out_ready},   32'd1);
        buf_out_arm = 1'b0;
        tick();

        // oversize packet: 1100 bytes, data = low byte of index
        for (int i = 0; i < 1100; i++) begin
            send_byte(8'(i), (i == 1099) ? 1'b1 : 1'b0);
            if (i == 1022) chk("ovf_at_cap", {31'd0, buf_out_ovf}, 32'd0);
            if (i == 1023) chk("ovf_past_cap", {31'd0, buf_out_ovf}, 32'd1);
        end
        chk("big_len",     {22'd0, buf_out_len},     32'd1023);
        chk("big_ovf",     {31'd0, buf_out_ovf},     32'd1);
        chk("big_hasdata", {31'd0, buf_out_hasdata}, 32'd1);
        read_chk("big_rd1022", 11'd1022, 8'hFE);
        read_chk("big_rd_wrap", 11'd1029, 8'h05);
        release_pkt();
        chk("ovf_sticky", {31'd0, buf_out_ovf}, 32'd1);
        send_byte(8'h77, 1'b1);
        chk("ovf_clear", {31'd0, buf_out_ovf}, 32'd0);
        chk("one_len",   {22'd0, buf_out_len}, 32'd1);
        release_pkt();

        // zero-length packets on both instances
        usb_out_zlp = 1'b1;
        zlp_z       = 1'b1;
        tick();
        usb_out_zlp = 1'b0;
        zlp_z       = 1'b0;
        tick();
        chk("zlp_drop_hasdata", {31'd0, buf_out_hasdata}, 32'd0);
        chk("zlp_drop_ready",   {31'd0, usb_out_ready},   32'd1);
        chk("zlp_keep_hasdata", {31'd0, hasdata_z},       32'd1);
        chk("zlp_keep_len",     {22'd0, len_z},           32'd0);
        chk("zlp_keep_ready",   {31'd0, ready_z},         32'd0);
        arm_z = 1'b1;
        tick();
        chk("zlp_keep_ack", {31'd0, ack_z}, 32'd1);
        arm_z = 1'b0;
        tick();
        tick();
        chk("zlp_keep_rel", {31'd0, ready_z}, 32'd1);

`ifdef EP_OUT_STATS_EN
        chk("stat_pkt",    {16'd0, pkt_cnt},    32'd4);
        chk("stat_drop",   {24'd0, drop_cnt},   32'd2);
        chk("stat_pkt_z",  {16'd0, pkt_cnt_z},  32'd1);
        chk("stat_drop_z", {24'd0, drop_cnt_z}, 32'd0);
`endif

        // reset mid-fill
        for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i), 1'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid_rst_ready",   {31'd0, usb_out_ready},   32'd1);
        chk("mid_rst_hasdata", {31'd0, buf_out_hasdata}, 32'd0);
        chk("mid_rst_len",     {22'd0, buf_out_len},     32'd0);
        send_byte(8'h5A, 1'b1);
        chk("fresh_len",     {22'd0, buf_out_len},     32'd1);
        chk("fresh_hasdata", {31'd0, buf_out_hasdata}, 32'd1);
        read_chk("fresh_rd0", 11'd0, 8'h5A);

        // reset during handshake
        buf_out_arm = 1'b1;
        tick();
        chk("hs_ack", {31'd0, buf_out_arm_ack}, 32'd1);
        reset = 1'b0;
        tick();
        reset       = 1'b1;
        buf_out_arm = 1'b0;
        chk("hs_rst_ack",   {31'd0, buf_out_arm_ack}, 32'd0);
        chk("hs_rst_ready", {31'd0, usb_out_ready},   32'd1);
        chk("hs_rst_has",   {31'd0, buf_out_hasdata}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
